hex_dump_sequencer: RTL and testbench
=====================================

// Module: hex_dump_sequencer
// PURPOSE
//  Serialises a WIDTH-bit binary word into ASCII hex characters, MS nibble first.
//  - Nibbles are stepped through the team's combinational bin2AsciiHex converter
//    (0-9 -> 0x30-0x39, a-f -> 0x61-0x66).
//  - Characters are emitted one per valid/ready handshake to the UART TX front end.
//  - Sits between the lab datapath result registers and the serial console.
// PARAMETERS
//  NIBBLES   4   hex digits per word; word width = 4*NIBBLES (legal range 1..16)
// PORTS
//  clk         in   1          system clock, all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  word_valid  in   1          word_in is presented for capture
//  word_in     in   4*NIBBLES  binary word to print
//  word_ready  out  1          high only in IDLE; capture occurs on word_valid & word_ready
//  char_out    out  8          ASCII character to transmit (registered)
//  char_valid  out  1          char_out is valid (registered)
//  char_ready  in   1          consumer accepts char_out this cycle
//  done        out  1          1-cycle pulse on the cycle after the final char handshake
// BEHAVIOUR
//  - Reset: state=IDLE, word_ready=1, char_valid=0, char_out=8'h00, done=0,
//    shift register and nibble counter cleared.
//  - FSM states: IDLE -> DIGIT -> [CR -> LF] -> IDLE.
//  - IDLE, capture (word_valid & word_ready): latch word_in, nib_cnt=NIBBLES-1, go DIGIT.
//    Next cycle: char_valid=1, char_out = ASCII of word[4*NIBBLES-1 -: 4].
//    Capture-to-first-char latency = 1 clock.
//  - DIGIT, on char_valid & char_ready:
//    - If nib_cnt != 0: shift word left 4, decrement nib_cnt, present the next digit
//      on the following cycle. char_valid stays high, so back-to-back characters
//      need no bubble.
//    - If nib_cnt == 0: go CR if HEX_DUMP_CRLF_EN is defined, else go IDLE.
//  - Back-pressure: while char_valid & ~char_ready, char_out and all state hold
//    unchanged. char_valid never drops without a handshake (except on rst).
//  - Completion, final handshake:
//    - char_valid=0 and word_ready=1 next cycle; done=1 for exactly that cycle.
//    - Minimum one IDLE cycle between words; a new capture is allowed in the same
//      cycle as done.
//  - word_valid while busy (word_ready=0): ignored, no capture, no side effect.
//    Sender must hold the word.
//  - rst mid-word (any state, including stalled): partial word dropped, no done
//    pulse, char_valid=0 on the next edge.
//  - Characters per word = NIBBLES (+2 with CRLF). Leading zeros are always printed.
//    nib_cnt width = clog2(NIBBLES), minimum 1.
// CONFIGURATION
//  - HEX_DUMP_CRLF_EN defined:
//    - After the last digit, emit 8'h0D (state CR), then 8'h0A (state LF).
//    - Each is its own handshake, same back-pressure rules; done follows the LF handshake.
//  - Undefined: CR/LF states are not built; done follows the last digit handshake.
// TESTING
//  1. NIBBLES=4, word 16'h1A3F, char_ready=1 -> char_out 31,61,33,66 on 4 consecutive
//     cycles; done 1 cycle after 0x66.
//  2. Word 16'h0000, then 16'hFFFF -> 30,30,30,30, then 66,66,66,66.
//     word_ready low from capture until done.
//  3. Word 16'hBEEF, char_ready low for 3 cycles on the 2nd char -> char_out holds 0x65,
//     char_valid stays 1; sequence 62,65,65,66 completes intact.
//  4. rst asserted while stalled on the 3rd char of 16'h1234 -> next cycle char_valid=0,
//     word_ready=1, no done. Next word 16'h5678 prints 35,36,37,38.
//  5. word_valid pulsed with 16'h9999 during an active 16'h1234 dump -> ignored;
//     output is 31,32,33,34 only.
//  6. HEX_DUMP_CRLF_EN, NIBBLES=2, word 8'hC0 -> 63,30,0D,0A; done after 0x0A.

Source files
------------

// File: rtl/hex_dump_sequencer_if.sv
// Word-in / character-out handshake bundle for hex_dump_sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to whatever feeds words and sinks chars.
interface hex_dump_sequencer_if #(
  parameter int NIBBLES = 4
);
  logic                   word_valid;
  logic [4*NIBBLES-1:0]   word_in;
  logic                   word_ready;
  logic [7:0]             char_out;
  logic                   char_valid;
  logic                   char_ready;
  logic                   done;

  modport slave (
    input  word_valid, word_in, char_ready,
    output word_ready, char_out, char_valid, done
  );

  modport master (
    output word_valid, word_in, char_ready,
    input  word_ready, char_out, char_valid, done
  );
endinterface

// File: rtl/hex_dump_sequencer.sv
// Serialises a 4*NIBBLES-bit word into ASCII hex characters, MS nibble first.
// Optional: define HEX_DUMP_CRLF_EN to append CR, LF after the last digit.
module hex_dump_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_dump_sequencer_if.slave   bus,
  output logic [1:0]            dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Once valid is raised, it stays high and its data stays stable until that transfer (or rst).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1
`ifdef HEX_DUMP_CRLF_EN
    ,
    CR    = 2'd2,
    LF    = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   nib_cnt_q, nib_cnt_d;
  logic [7:0]      char_out_q, char_out_d;
  logic            char_valid_q, char_valid_d;
  logic            done_q, done_d;
  logic [W-1:0]    shift_next;
  logic            char_hs;

  function automatic logic [7:0] bin2_ascii_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign shift_next = shift_q << 4;
  assign char_hs    = char_valid_q & bus.char_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    nib_cnt_d    = nib_cnt_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.word_valid) begin
          shift_d      = bus.word_in;
          nib_cnt_d    = CW'(NIBBLES - 1);
          char_out_d   = bin2_ascii_hex(bus.word_in[W-1 -: 4]);
          char_valid_d = 1'b1;
          state_d      = DIGIT;
        end
      end
      DIGIT: begin
        if (char_hs) begin
          if (nib_cnt_q != '0) begin
            shift_d    = shift_next;
            nib_cnt_d  = nib_cnt_q - 1'b1;
            char_out_d = bin2_ascii_hex(shift_next[W-1 -: 4]);
          end else begin
`ifdef HEX_DUMP_CRLF_EN
            char_out_d   = 8'h0D;
            state_d      = CR;
`else
            char_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = IDLE;
`endif
          end
        end
      end
`ifdef HEX_DUMP_CRLF_EN
      CR: begin
        if (char_hs) begin
          char_out_d = 8'h0A;
          state_d    = LF;
        end
      end
      LF: begin
        if (char_hs) begin
          char_valid_d = 1'b0;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: begin
        char_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      nib_cnt_q    <= '0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      nib_cnt_q    <= nib_cnt_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.word_ready = (state_q == IDLE);
  assign bus.char_out   = char_out_q;
  assign bus.char_valid = char_valid_q;
  assign bus.done       = done_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_hex_dump_sequencer.sv
// Directed and randomly stalled checks of hex_dump_sequencer against a character scoreboard.
module tb_hex_dump_sequencer;
  localparam int NIB   = 4;
  localparam int W     = 4 * NIB;
`ifdef HEX_DUMP_CRLF_EN
  localparam int CHARS = NIB + 2;
`else
  localparam int CHARS = NIB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         vectors = 0;
  int         miscompares = 0;
  logic       done_exp = 1'b0;
  logic       rand_ready = 1'b0;
  logic [8:0] exp_q[$];   // {last_char_of_word, char}

  hex_dump_sequencer_if #(.NIBBLES(NIB)) bus ();

  hex_dump_sequencer #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = NIB - 1; i >= 0; i--)
      exp_q.push_back({(CHARS == NIB) && (i == 0), hex_char(w[4*i +: 4])});
`ifdef HEX_DUMP_CRLF_EN
    exp_q.push_back({1'b0, 8'h0D});
    exp_q.push_back({1'b1, 8'h0A});
`endif
  endtask

  // Drives word_valid for exactly one capture edge; returns 1 time unit after it.
  task automatic send_word(input logic [W-1:0] w);
    check("word_ready_before_send", {31'd0, bus.word_ready}, 32'd1);
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    push_word(w);
    @(posedge clk) #1;
    bus.word_valid = 1'b0;
    bus.word_in    = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && bus.word_ready === 1'b1 && bus.char_valid === 1'b0) && n < 300) begin
      @(posedge clk) #1;
      if (rand_ready) bus.char_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("wait_idle_timeout", n, (n < 300) ? n : 300'd0);
    bus.char_ready = 1'b1;
  endtask

  // Scoreboard monitor: inputs change only just after posedge, so negedge sees the values for the next edge.
  always @(negedge clk) begin
    logic [8:0] e;
    check("done", {31'd0, bus.done}, {31'd0, done_exp});
    done_exp = 1'b0;
    if (!rst && bus.char_valid === 1'b1 && bus.char_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_char", {24'd0, bus.char_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("char_out", {24'd0, bus.char_out}, {24'd0, e[7:0]});
        done_exp = e[8];
      end
    end
  end

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.char_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_ready", {31'd0, bus.word_ready}, 32'd1);
    check("rst_char_valid", {31'd0, bus.char_valid}, 32'd0);
    check("rst_char_out",   {24'd0, bus.char_out},   32'd0);
    check("rst_done",       {31'd0, bus.done},       32'd0);
    check("rst_state",      {30'd0, dbg_state},      32'd0);
    rst = 1'b0;
    @(posedge clk) #1;

    // 1: latency of one clock, back-to-back chars, done CHARS cycles after capture
    send_word(16'h1A3F);
    check("t1_first_valid", {31'd0, bus.char_valid}, 32'd1);
    check("t1_first_char",  {24'd0, bus.char_out},   32'h31);
    repeat (CHARS) @(posedge clk);
    #1;
    check("t1_done_timing", {31'd0, bus.done}, 32'd1);
    check("t1_ready_on_done", {31'd0, bus.word_ready}, 32'd1);
    wait_idle();

    // 2: all-zero then all-ones; busy window between capture and done
    send_word(16'h0000);
    check("t2_busy", {31'd0, bus.word_ready}, 32'd0);
    wait_idle();
    send_word(16'hFFFF);
    repeat (CHARS - 1) begin
      check("t2_busy_ff", {31'd0, bus.word_ready}, 32'd0);
      @(posedge clk) #1;
    end
    check("t2_busy_last", {31'd0, bus.word_ready}, 32'd0);
    wait_idle();

    // 3: stall three cycles on the second char
    send_word(16'hBEEF);
    @(posedge clk) #1;
    bus.char_ready = 1'b0;
    repeat (3) begin
      @(posedge clk) #1;
      check("t3_hold_char",  {24'd0, bus.char_out},   32'h65);
      check("t3_hold_valid", {31'd0, bus.char_valid}, 32'd1);
    end
    bus.char_ready = 1'b1;
    wait_idle();

    // 4: reset while stalled on third char drops the word with no done
    send_word(16'h1234);
    repeat (2) @(posedge clk);
    #1;
    check("t4_third_char", {24'd0, bus.char_out}, 32'h33);
    bus.char_ready = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk) #1;
    rst = 1'b0;
    check("t4_valid_cleared", {31'd0, bus.char_valid}, 32'd0);
    check("t4_ready_after_rst", {31'd0, bus.word_ready}, 32'd1);
    check("t4_no_done", {31'd0, bus.done}, 32'd0);
    bus.char_ready = 1'b1;
    send_word(16'h5678);
    wait_idle();

    // 5: word_valid while busy is ignored
    send_word(16'h1234);
    bus.word_valid = 1'b1;
    bus.word_in    = 16'h9999;
    repeat (2) @(posedge clk);
    #1;
    check("t5_still_busy", {31'd0, bus.word_ready}, 32'd0);
    bus.word_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_extra", {31'd0, bus.char_valid}, 32'd0);

    // Random words with random back-pressure
    rand_ready = 1'b1;
    repeat (8) begin
      send_word(W'($urandom_range(0, 16'hFFFF)));
      wait_idle();
    end
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
